// File: rtl/ipu_pkg.sv
// Shared image-pipeline types: coordinate width and the packed (X,Y) pair
// exchanged between the detector and its consumers.
package ipu_pkg;

  localparam int COORD_W = 11;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

endpackage

// File: rtl/coord_readout_if.sv
// Detector-stream input, reader handshake and status outputs of coord_readout.
// The master side drives the detector/reader strobes; the slave side is the block.
interface coord_readout_if
  import ipu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int OVF_W = 8
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [COORD_W-1:0] iX;
  logic [COORD_W-1:0] iY;
  logic               iDVAL;
  logic               iRD;
  logic               iClrOvf;
  logic [COORD_W-1:0] oRdX;
  logic [COORD_W-1:0] oRdY;
  logic               oRdVAL;
  logic               oFull;
  logic [CNT_W-1:0]   oCount;
  logic [COORD_W-1:0] oLastX;
  logic [COORD_W-1:0] oLastY;
  logic               oOvf;
  logic [OVF_W-1:0]   oOvfCnt;
  logic               oStale;

  modport slave (
    input  iX, iY, iDVAL, iRD, iClrOvf,
    output oRdX, oRdY, oRdVAL, oFull, oCount, oLastX, oLastY, oOvf, oOvfCnt, oStale
  );

  modport master (
    output iX, iY, iDVAL, iRD, iClrOvf,
    input  oRdX, oRdY, oRdVAL, oFull, oCount, oLastX, oLastY, oOvf, oOvfCnt, oStale
  );

endinterface

// File: rtl/coord_readout_fifo.sv
// First-word-fall-through FIFO with a registered head word, so dout/dVal/full/count
// all come straight from flops. Occupancy is tracked by its own counter.
module sync_fifo_fwft #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   wrReq,
  input  logic [WIDTH-1:0]       din,
  input  logic                   rdReq,
  output logic [WIDTH-1:0]       dout,
  output logic                   dVal,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] rdPtrNxt;
  logic [PTR_W:0]   countNxt;
  logic [WIDTH-1:0] headNxt;
  logic             push;
  logic             pop;

  always_comb begin
    pop      = rdReq && dVal;
    push     = wrReq && (!full || pop);
    rdPtrNxt = rdPtr + PTR_W'(pop);
    countNxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    headNxt  = '0;
    // The only time the new head is the word being written is when it lands alone
    if (countNxt != '0) begin
      headNxt = (push && (wrPtr == rdPtrNxt)) ? din : mem[rdPtrNxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= din;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      dVal  <= 1'b0;
      full  <= 1'b0;
      dout  <= '0;
    end else begin
      wrPtr <= wrPtr + PTR_W'(push);
      rdPtr <= rdPtrNxt;
      count <= countNxt;
      dVal  <= (countNxt != '0);
      full  <= (countNxt == (PTR_W+1)'(DEPTH));
      dout  <= headNxt;
    end
  end

endmodule

// File: rtl/coord_readout.sv
// Consumer end of the detected-coordinate stream: FWFT buffer for the reader,
// newest-point register, saturating drop counter and a stale-tracker timer.
module coord_readout
  import ipu_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int STALE_CYC = 2500000,
  parameter int OVF_W     = 8
) (
  input  logic            iCLK,
  input  logic            iRST,
  coord_readout_if.slave  bus
);

  localparam int STALE_W = $clog2(STALE_CYC + 1);

  coord_t             wrData;
  coord_t             rdData;
  logic               drop;
  logic [COORD_W-1:0] lastX;
  logic [COORD_W-1:0] lastY;
  logic               ovf;
  logic [OVF_W-1:0]   ovfCnt;
  logic [STALE_W-1:0] staleCnt;
  logic               stale;

  function automatic logic [OVF_W-1:0] satInc(input logic [OVF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign wrData = {bus.iX, bus.iY};

  sync_fifo_fwft #(
    .WIDTH ($bits(coord_t)),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk   (iCLK),
    .rstN  (iRST),
    .wrReq (bus.iDVAL),
    .din   (wrData),
    .rdReq (bus.iRD),
    .dout  (rdData),
    .dVal  (bus.oRdVAL),
    .full  (bus.oFull),
    .count (bus.oCount)
  );

  // A pop in the same cycle frees the slot, so a full FIFO only drops without one
  assign drop = bus.iDVAL && bus.oFull && !(bus.iRD && bus.oRdVAL);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      lastX    <= '0;
      lastY    <= '0;
      ovf      <= 1'b0;
      ovfCnt   <= '0;
      staleCnt <= '0;
      stale    <= 1'b1;
    end else begin
      if (bus.iDVAL) begin
        lastX <= bus.iX;
        lastY <= bus.iY;
      end
      if (bus.iClrOvf) begin
        ovf    <= 1'b0;
        ovfCnt <= '0;
      end else if (drop) begin
        ovf    <= 1'b1;
        ovfCnt <= satInc(ovfCnt);
      end
      if (bus.iDVAL) begin
        staleCnt <= '0;
        stale    <= 1'b0;
      end else if (staleCnt != STALE_W'(STALE_CYC)) begin
        staleCnt <= staleCnt + 1'b1;
        if (staleCnt == STALE_W'(STALE_CYC - 1)) stale <= 1'b1;
      end
    end
  end

  assign bus.oRdX    = rdData.x;
  assign bus.oRdY    = rdData.y;
  assign bus.oLastX  = lastX;
  assign bus.oLastY  = lastY;
  assign bus.oOvf    = ovf;
  assign bus.oOvfCnt = ovfCnt;
  assign bus.oStale  = stale;

endmodule

// File: tb/tb_coord_readout.sv
// Directed bench for coord_readout with a queue scoreboard of accepted samples
// and a small reference model of the drop, latest and stale registers.
module tb_coord_readout;
  import ipu_pkg::*;

  localparam int DEPTH     = 8;
  localparam int STALE_CYC = 16;
  localparam int OVF_W     = 8;

  logic clk;
  logic rstN;

  coord_readout_if #(.DEPTH(DEPTH), .OVF_W(OVF_W)) bus ();

  coord_readout #(
    .DEPTH     (DEPTH),
    .STALE_CYC (STALE_CYC),
    .OVF_W     (OVF_W)
  ) dut (
    .iCLK (clk),
    .iRST (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     vectors = 0;
  int     miscompares = 0;
  coord_t sb[$];
  bit     mOvf;
  int     mOvfCnt;
  int     mLastX, mLastY;
  int     mStaleCnt;
  bit     mStale;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    sb.delete();
    mOvf = 0; mOvfCnt = 0; mLastX = 0; mLastY = 0; mStaleCnt = 0; mStale = 1;
  endtask

  task automatic checkState();
    chk("count", bus.oCount, sb.size());
    chk("rdVal", bus.oRdVAL, sb.size() != 0);
    chk("full", bus.oFull, sb.size() == DEPTH);
    chk("lastX", bus.oLastX, mLastX);
    chk("lastY", bus.oLastY, mLastY);
    chk("ovf", bus.oOvf, mOvf);
    chk("ovfCnt", bus.oOvfCnt, mOvfCnt);
    chk("stale", bus.oStale, mStale);
    if (sb.size() != 0) chk("head", {bus.oRdX, bus.oRdY}, sb[0]);
  endtask

  // One clock: drive, score the pop against the current head, step, re-check
  task automatic cyc(input bit dv, input int x, input int y, input bit rd, input bit clr);
    coord_t e;
    coord_t popped;
    bit full, pop, push, drop;
    bus.iDVAL = dv; bus.iX = 11'(x); bus.iY = 11'(y); bus.iRD = rd; bus.iClrOvf = clr;
    e.x = 11'(x); e.y = 11'(y);
    full = (sb.size() == DEPTH);
    pop  = rd && (sb.size() != 0);
    push = dv && (!full || pop);
    drop = dv && full && !pop;
    if (pop) begin
      popped = sb.pop_front();
      chk("popData", {bus.oRdX, bus.oRdY}, popped);
    end
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    if (clr) begin
      mOvf = 0; mOvfCnt = 0;
    end else if (drop) begin
      mOvf = 1;
      if (mOvfCnt != 255) mOvfCnt++;
    end
    if (dv) begin
      mLastX = x; mLastY = y; mStaleCnt = 0; mStale = 0;
    end else if (mStaleCnt < STALE_CYC) begin
      mStaleCnt++;
      if (mStaleCnt == STALE_CYC) mStale = 1;
    end
    bus.iDVAL = 0; bus.iRD = 0; bus.iClrOvf = 0;
    checkState();
  endtask

  initial begin
    rstN = 1'b0;
    bus.iX = '0; bus.iY = '0; bus.iDVAL = 0; bus.iRD = 0; bus.iClrOvf = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    #1;
    chk("rstRdX", bus.oRdX, 0);
    chk("rstRdY", bus.oRdY, 0);
    checkState();

    // First sample falls through one cycle after the strobe
    cyc(1, 100, 200, 0, 0);
    chk("fwftX", bus.oRdX, 100);
    chk("fwftY", bus.oRdY, 200);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // Fill, drop a ninth, drain in order
    for (int i = 0; i < DEPTH; i++) cyc(1, i * 3 + 1, i * 5 + 2, 0, 0);
    chk("fullFlag", bus.oFull, 1);
    cyc(1, 5, 5, 0, 0);
    chk("dropCnt", bus.oOvfCnt, 1);
    chk("dropLastX", bus.oLastX, 5);
    chk("dropCount", bus.oCount, 8);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);

    // Push and pop together on a full FIFO
    for (int i = 0; i < DEPTH; i++) cyc(1, 40 + i, 60 + i, 0, 0);
    cyc(1, 77, 88, 1, 0);
    chk("fullPushPop", bus.oFull, 1);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 1, 0);

    // Pointer wrap with interleaved single pops
    for (int i = 0; i < 20; i++) begin
      cyc(1, 300 + i, 900 - i, 1, 0);
      if (i % 2 == 1) cyc(0, 0, 0, 1, 0);
      else cyc(1, 500 + i, 700 + i, 0, 0);
      chk("countBound", bus.oCount <= DEPTH, 1);
    end
    while (sb.size() != 0) cyc(0, 0, 0, 1, 0);

    // Stale timer
    cyc(1, 11, 22, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < STALE_CYC - 2; i++) cyc(0, 0, 0, 0, 0);
    chk("staleEarly", bus.oStale, 0);
    cyc(0, 0, 0, 0, 0);
    chk("staleSet", bus.oStale, 1);
    cyc(1, 33, 44, 0, 0);
    chk("staleClr", bus.oStale, 0);
    cyc(0, 0, 0, 1, 0);

    // Saturating drop count, then clear racing a drop
    for (int i = 0; i < DEPTH; i++) cyc(1, 600 + i, 610 + i, 0, 0);
    for (int i = 0; i < 300; i++) cyc(1, i, i + 1, 0, 0);
    chk("ovfSat", bus.oOvfCnt, 255);
    cyc(1, 9, 9, 0, 1);
    chk("clrCnt", bus.oOvfCnt, 0);
    chk("clrOvf", bus.oOvf, 0);

    // Asynchronous reset in the middle of traffic
    cyc(1, 1, 2, 1, 0);
    rstN = 1'b0;
    #2;
    chk("asyncRdVal", bus.oRdVAL, 0);
    chk("asyncCount", bus.oCount, 0);
    modelReset();
    @(posedge clk); #1;
    rstN = 1'b1;
    #1;
    checkState();

    // Read while empty has no effect
    cyc(0, 0, 0, 1, 0);
    cyc(1, 123, 456, 0, 0);
    cyc(0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
